bsg_mem_nr1w_sync: RTL and testbench

//   Parametrised register-file RAM: rports_p synchronous read ports and one write port.

---
 rtl/bsg_mem_nr1w_pkg.sv | 19 +
 rtl/bsg_mem_clear_sweep.sv | 60 ++++++
 rtl/bsg_mem_nr1w_sync.sv | 126 ++++++++++++
 tb/tb_bsg_mem_nr1w_sync.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mem_nr1w_pkg.sv
// Shared types and helpers for the bsg_mem_nr1w_sync register-file RAM.
// Parity storage is enabled by defining BSG_MEM_NR1W_PARITY_EN.
package bsg_mem_nr1w_pkg;

   typedef enum logic [0:0] {eClear, eReady} bsg_mem_nr1w_state_e;

   // Widest data word the parity helper accepts; callers zero-extend to this.
   localparam int max_width_lp = 1024;

   function automatic int safe_clog2_f(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Even parity: returns the bit that makes the total xor of {data,bit} zero.
   function automatic logic parity_f(input logic [max_width_lp-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/bsg_mem_clear_sweep.sv
// Post-reset clear sequencer: walks every entry once, then declares the RAM ready.
// state  | meaning
// eClear | zeroing mem[clr_addr] each cycle, user traffic ignored
// eReady | sweep finished, read/write ports live
module bsg_mem_clear_sweep
   import bsg_mem_nr1w_pkg::*;
#(
   parameter int els_p         = 32,
   parameter int addr_width_lp = safe_clog2_f(els_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   output logic                     clr_v,
   output logic [addr_width_lp-1:0] clr_addr,
   output logic                     ready
);

   localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

   bsg_mem_nr1w_state_e      state_r, state_n;
   logic [addr_width_lp-1:0] addr_r, addr_n;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r <= eClear;
         addr_r  <= '0;
      end else begin
         state_r <= state_n;
         addr_r  <= addr_n;
      end
   end

   always_comb begin
      state_n = state_r;
      addr_n  = addr_r;
      clr_v   = 1'b0;
      case (state_r)
         eClear: begin
            clr_v = 1'b1;
            if (addr_r == last_addr_lp) begin
               state_n = eReady;
               addr_n  = '0;
            end else begin
               addr_n  = addr_r + 1'b1;
            end
         end
         eReady: begin
            state_n = eReady;
         end
         default: begin
            state_n = eClear;
            addr_n  = '0;
         end
      endcase
   end

   assign clr_addr = addr_r;
   assign ready    = (state_r == eReady);

endmodule

// File: rtl/bsg_mem_nr1w_sync.sv
// N-read / 1-write synchronous register file with hardware clear sweep after reset.
// Define BSG_MEM_NR1W_PARITY_EN to store an even-parity bit per entry and report r_perr_o.
module bsg_mem_nr1w_sync
   import bsg_mem_nr1w_pkg::*;
#(
   parameter int width_p                = 32,
   parameter int els_p                  = 32,
   parameter int rports_p               = 2,
   parameter int read_write_same_addr_p = 0,
   parameter int addr_width_lp          = safe_clog2_f(els_p)
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   output logic                              ready_o,
   input  logic                              w_v_i,
   input  logic [addr_width_lp-1:0]          w_addr_i,
   input  logic [width_p-1:0]                w_data_i,
   input  logic [rports_p-1:0]               r_v_i,
   input  logic [rports_p*addr_width_lp-1:0] r_addr_i,
   output logic [rports_p-1:0]               r_v_o,
   output logic [rports_p*width_p-1:0]       r_data_o,
   output logic [rports_p-1:0]               r_perr_o
);

`ifdef BSG_MEM_NR1W_PARITY_EN
   localparam int store_w_lp = width_p + 1;
`else
   localparam int store_w_lp = width_p;
`endif

   localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

   logic                     clr_v, ready;
   logic [addr_width_lp-1:0] clr_addr;

   bsg_mem_clear_sweep #(
      .els_p         (els_p),
      .addr_width_lp (addr_width_lp)
   ) sweep (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clr_v     (clr_v),
      .clr_addr  (clr_addr),
      .ready     (ready)
   );

   assign ready_o = ready;

   logic [store_w_lp-1:0] mem [els_p];

   logic                     mem_we;
   logic [addr_width_lp-1:0] mem_waddr;
   logic [store_w_lp-1:0]    mem_wdata;
   logic                     w_in_range;

   assign w_in_range = ({1'b0, w_addr_i} < els_lp);

   // Sweep owns the write port until ready; an all-zero word already has even parity.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_addr;
      mem_wdata = '0;
      if (reset_n_i) begin
         if (clr_v) begin
            mem_we = 1'b1;
         end else if (ready && w_v_i && w_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = w_addr_i;
`ifdef BSG_MEM_NR1W_PARITY_EN
            mem_wdata = {parity_f(max_width_lp'(w_data_i)), w_data_i};
`else
            mem_wdata = w_data_i;
`endif
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   for (genvar i = 0; i < rports_p; i++) begin : rp
      logic [addr_width_lp-1:0] ra;
      logic                     in_range, bypass;
      logic [store_w_lp-1:0]    rword;
      logic                     rv_r;
      logic [width_p-1:0]       rd_r;

      assign ra       = r_addr_i[i*addr_width_lp +: addr_width_lp];
      assign in_range = ({1'b0, ra} < els_lp);
      assign bypass   = (read_write_same_addr_p != 0) && w_v_i && (w_addr_i == ra);
      assign rword    = in_range ? mem[ra] : '0;

      always_ff @(posedge clk_i) begin
         if (!reset_n_i) begin
            rv_r <= 1'b0;
            rd_r <= '0;
         end else if (!ready) begin
            rv_r <= 1'b0;
         end else begin
            rv_r <= r_v_i[i];
            if (r_v_i[i]) begin
               if (!in_range)   rd_r <= '0;
               else if (bypass) rd_r <= w_data_i;
               else             rd_r <= rword[width_p-1:0];
            end
         end
      end

`ifdef BSG_MEM_NR1W_PARITY_EN
      logic pe_r;
      // Bypassed and out-of-range reads never flag: their data is not from storage.
      always_ff @(posedge clk_i) begin
         if (!reset_n_i || !ready) pe_r <= 1'b0;
         else pe_r <= r_v_i[i] && in_range && !bypass && (^rword);
      end
      assign r_perr_o[i] = pe_r;
`else
      assign r_perr_o[i] = 1'b0;
`endif

      assign r_v_o[i]                      = rv_r;
      assign r_data_o[i*width_p +: width_p] = rd_r;
   end

endmodule

// File: tb/tb_bsg_mem_nr1w_sync.sv
// Self-checking bench: a 32-entry read-first RAM and a 24-entry write-first RAM share stimulus.
module tb_bsg_mem_nr1w_sync;

   logic        clk;
   logic        rst_n;
   logic        w_v;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [1:0]  r_v;
   logic [9:0]  r_addr;

   logic        d_rdy [2];
   logic [1:0]  d_rv  [2];
   logic [63:0] d_rd  [2];
   logic [1:0]  d_pe  [2];

   int n_checks = 0;
   int n_fail   = 0;

   int els [2] = '{32, 24};
   int pol [2] = '{0, 1};

   // reference model state
   logic [31:0] m    [2][32];
   bit          bad  [2][32];
   bit          rdy  [2];
   int          cnt  [2];
   logic [1:0]  erv  [2];
   logic [31:0] erd  [2][2];
   logic [1:0]  epe  [2];

   bsg_mem_nr1w_sync #(.width_p(32), .els_p(32), .rports_p(2), .read_write_same_addr_p(0)) dut_a (
      .clk_i(clk), .reset_n_i(rst_n), .ready_o(d_rdy[0]),
      .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
      .r_v_i(r_v), .r_addr_i(r_addr),
      .r_v_o(d_rv[0]), .r_data_o(d_rd[0]), .r_perr_o(d_pe[0]));

   bsg_mem_nr1w_sync #(.width_p(32), .els_p(24), .rports_p(2), .read_write_same_addr_p(1)) dut_b (
      .clk_i(clk), .reset_n_i(rst_n), .ready_o(d_rdy[1]),
      .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
      .r_v_i(r_v), .r_addr_i(r_addr),
      .r_v_o(d_rv[1]), .r_data_o(d_rd[1]), .r_perr_o(d_pe[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reset zeroes the whole array at once and starts an els-cycle blackout.
   task automatic model_cycle();
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            rdy[d] = 0;
            cnt[d] = els[d];
            for (int k = 0; k < 32; k++) begin
               m[d][k]   = '0;
               bad[d][k] = 0;
            end
            erv[d] = '0;
            epe[d] = '0;
            erd[d][0] = '0;
            erd[d][1] = '0;
         end else if (!rdy[d]) begin
            cnt[d] = cnt[d] - 1;
            if (cnt[d] == 0) rdy[d] = 1;
            erv[d] = '0;
            epe[d] = '0;
         end else begin
            for (int p = 0; p < 2; p++) begin
               int a;
               a = int'(r_addr[p*5 +: 5]);
               erv[d][p] = r_v[p];
               epe[d][p] = 1'b0;
               if (r_v[p]) begin
                  if (a >= els[d]) erd[d][p] = '0;
                  else if (pol[d] == 1 && w_v && int'(w_addr) == a) erd[d][p] = w_data;
                  else begin
                     erd[d][p] = m[d][a];
                     epe[d][p] = bad[d][a];
                  end
               end
            end
            if (w_v && int'(w_addr) < els[d]) begin
               m[d][w_addr]   = w_data;
               bad[d][w_addr] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_cycle();
      @(negedge clk);
   endtask

   task automatic idle();
      w_v = 0; r_v = 2'b00; w_addr = '0; w_data = '0; r_addr = '0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      w_v = 1; w_addr = 5'd4; w_data = 32'hFFFF_FFFF; r_v = 2'b11;
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (d_rdy[d] !== 1'b0 || d_rv[d] !== 2'b00 || d_rd[d] !== 64'h0 || d_pe[d] !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: rdy=%b rv=%b rd=%h pe=%b required 0/00/0/00", d, d_rdy[d], d_rv[d], d_rd[d], d_pe[d]);
         end
      end
      rst_n = 1;
      for (int c = 1; c <= 36; c++) begin
         w_v    = (c <= 24) ? 1'($urandom_range(0, 1)) : 1'b0;
         w_addr = 5'($urandom_range(0, 31));
         w_data = $urandom;
         r_v    = 2'($urandom_range(0, 3));
         r_addr = 10'($urandom);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (d_rdy[d] !== (c >= els[d])) begin
               n_fail++;
               $display("FAIL sweep_ready dut%0d cycle %0d: got %b required %b", d, c, d_rdy[d], (c >= els[d]));
            end
            if (c <= els[d]) begin
               n_checks++;
               if (d_rv[d] !== 2'b00) begin
                  n_fail++;
                  $display("FAIL clear_rv dut%0d cycle %0d: got %b required 00", d, c, d_rv[d]);
               end
            end
         end
      end
      idle();
      tick();
      for (int a = 0; a < 32; a++) begin
         r_v = 2'b11;
         r_addr = {5'(31 - a), 5'(a)};
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (d_rv[d] !== 2'b11 || d_rd[d] !== 64'h0) begin
               n_fail++;
               $display("FAIL cleared_read dut%0d addr %0d: rv=%b rd=%h required 11/0", d, a, d_rv[d], d_rd[d]);
            end
         end
      end
      idle();
   endtask

   task automatic test_write_read();
      w_v = 1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF;
      tick();
      w_v = 0; r_v = 2'b11; r_addr = {5'd6, 5'd5};
      tick();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (d_rv[d] !== 2'b11 || d_rd[d] !== {32'h0, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL write_read dut%0d: rv=%b rd=%h required 11/%h", d, d_rv[d], d_rd[d], {32'h0, 32'hDEAD_BEEF});
         end
      end
      idle();
   endtask

   task automatic test_collision();
      w_v = 1; w_addr = 5'd7; w_data = 32'hA5A5_A5A5;
      tick();
      w_data = 32'h0000_1234; r_v = 2'b11; r_addr = {5'd7, 5'd7};
      tick();
      for (int d = 0; d < 2; d++) begin
         logic [31:0] req;
         req = (pol[d] == 0) ? 32'hA5A5_A5A5 : 32'h0000_1234;
         n_checks++;
         if (d_rv[d] !== 2'b11 || d_rd[d] !== {req, req}) begin
            n_fail++;
            $display("FAIL collision dut%0d: rv=%b rd=%h required 11/%h", d, d_rv[d], d_rd[d], {req, req});
         end
      end
      w_v = 0; r_v = 2'b01;
      tick();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (d_rd[d][31:0] !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL after_collision dut%0d: got %h required 00001234", d, d_rd[d][31:0]);
         end
      end
      idle();
   endtask

   task automatic test_out_of_range();
      w_v = 1; w_addr = 5'd30; w_data = 32'h0000_00FF;
      tick();
      w_v = 0; r_v = 2'b01; r_addr = {5'd0, 5'd30};
      tick();
      n_checks++;
      if (d_rv[1] !== 2'b01 || d_rd[1][31:0] !== 32'h0 || d_pe[1] !== 2'b00) begin
         n_fail++;
         $display("FAIL oor_read dut1: rv=%b rd=%h pe=%b required 01/0/00", d_rv[1], d_rd[1][31:0], d_pe[1]);
      end
      n_checks++;
      if (d_rd[0][31:0] !== 32'h0000_00FF) begin
         n_fail++;
         $display("FAIL inrange_30 dut0: got %h required 000000ff", d_rd[0][31:0]);
      end
      for (int a = 0; a < 24; a++) begin
         r_v = 2'b01; r_addr = {5'd0, 5'(a)};
         tick();
         n_checks++;
         if (d_rd[1][31:0] !== erd[1][0] || d_rv[1] !== 2'b01) begin
            n_fail++;
            $display("FAIL legal_unchanged dut1 addr %0d: got %h required %h", a, d_rd[1][31:0], erd[1][0]);
         end
      end
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         w_v    = 1'($urandom_range(0, 1));
         w_addr = 5'($urandom_range(0, 31));
         w_data = $urandom;
         r_v    = 2'($urandom_range(0, 3));
         r_addr = 10'($urandom);
         if ($urandom_range(0, 3) == 0) r_addr[4:0] = w_addr;
         if ($urandom_range(0, 5) == 0) r_addr[9:5] = r_addr[4:0];
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (d_rv[d] !== erv[d] || d_rd[d] !== {erd[d][1], erd[d][0]} || d_pe[d] !== epe[d]) begin
               n_fail++;
               $display("FAIL random dut%0d cycle %0d: rv=%b rd=%h pe=%b required %b/%h/%b", d, c, d_rv[d], d_rd[d], d_pe[d], erv[d], {erd[d][1], erd[d][0]}, epe[d]);
            end
         end
      end
      idle();
   endtask

   task automatic test_mid_reset();
      w_v = 1; w_addr = 5'd3; w_data = 32'h0000_0055; r_v = 2'b11; r_addr = {5'd9, 5'd3};
      tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (d_rdy[d] !== 1'b0 || d_rv[d] !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_drop dut%0d: rdy=%b rv=%b required 0/00", d, d_rdy[d], d_rv[d]);
         end
      end
      idle();
      for (int c = 1; c <= 32; c++) begin
         tick();
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (d_rdy[d] !== (c >= els[d])) begin
               n_fail++;
               $display("FAIL resweep_ready dut%0d cycle %0d: got %b required %b", d, c, d_rdy[d], (c >= els[d]));
            end
         end
      end
      r_v = 2'b11; r_addr = {5'd7, 5'd3};
      tick();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (d_rv[d] !== 2'b11 || d_rd[d] !== 64'h0) begin
            n_fail++;
            $display("FAIL rezeroed dut%0d: rv=%b rd=%h required 11/0", d, d_rv[d], d_rd[d]);
         end
      end
      idle();
   endtask

   task automatic test_parity();
      w_v = 1; w_addr = 5'd2; w_data = 32'h0000_000F;
      tick();
      idle();
`ifdef BSG_MEM_NR1W_PARITY_EN
      dut_a.mem[2][0] = ~dut_a.mem[2][0];
      dut_b.mem[2][0] = ~dut_b.mem[2][0];
      for (int d = 0; d < 2; d++) begin
         m[d][2][0] = ~m[d][2][0];
         bad[d][2]  = 1;
      end
`endif
      r_v = 2'b01; r_addr = {5'd0, 5'd2};
      tick();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (d_rv[d] !== 2'b01 || d_pe[d] !== epe[d] || d_rd[d][31:0] !== erd[d][0]) begin
            n_fail++;
            $display("FAIL parity_flip dut%0d: rv=%b pe=%b rd=%h required 01/%b/%h", d, d_rv[d], d_pe[d], d_rd[d][31:0], epe[d], erd[d][0]);
         end
      end
      idle();
      w_v = 1; w_addr = 5'd2; w_data = 32'h0000_000F;
      tick();
      w_v = 0; r_v = 2'b01; r_addr = {5'd0, 5'd2};
      tick();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (d_pe[d] !== 2'b00 || d_rd[d][31:0] !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL parity_rewrite dut%0d: pe=%b rd=%h required 00/0000000f", d, d_pe[d], d_rd[d][31:0]);
         end
      end
      idle();
   endtask

   initial begin
      rst_n = 0;
      idle();
      test_reset();
      test_write_read();
      test_collision();
      test_out_of_range();
      test_random();
      test_mid_reset();
      test_parity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
